// File: rtl/mdet_pkg.sv
// Shared types and constants for the multi-channel "first one" detector scheduler.
// Detector state encoding is fixed (IDLE=00, ONE=01, RUN=10); code 11 is never
// produced and decays to IDLE on the next step.
package mdet_pkg;

  typedef logic [1:0] det_state_t;

  localparam det_state_t ST_IDLE = 2'b00;
  localparam det_state_t ST_ONE  = 2'b01;
  localparam det_state_t ST_RUN  = 2'b10;

  // Width of the per-channel event counters (optional feature).
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mdet_sched_if.sv
// Handshake bundle for mdet_sched: per-channel bit offers in, single event stream out.
// master = channel sources + event consumer, slave = the scheduler.
interface mdet_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
);

  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_bit;
  logic [NCH-1:0] in_ready;
  logic           ev_valid;
  logic [CW-1:0]  ev_ch;
  logic           ev_ready;

  modport master (
    output in_valid, in_bit, ev_ready,
    input  in_ready, ev_valid, ev_ch
  );

  modport slave (
    input  in_valid, in_bit, ev_ready,
    output in_ready, ev_valid, ev_ch
  );

endinterface

// File: rtl/det_step.sv
// Combinational next-state function of one channel detector.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | last accepted bit was 0, or cleared / reset
//   ONE   | exactly one 1 seen since IDLE (event raised here)
//   RUN   | two or more consecutive 1s
//
// One instance is shared: only the granted channel steps in a given cycle.
module det_step
  import mdet_pkg::*;
(
  input  det_state_t state,
  input  logic       din,
  output det_state_t next_state,
  output logic       ev
);

  // A 0 always returns to IDLE; a 1 advances IDLE->ONE->RUN, RUN holds.
  always_comb begin
    next_state = ST_IDLE;
    if (din) begin
      case (state)
        ST_IDLE: next_state = ST_ONE;
        ST_ONE:  next_state = ST_RUN;
        ST_RUN:  next_state = ST_RUN;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign ev = (next_state == ST_ONE);

endmodule

// File: rtl/mdet_sched.sv
// Round-robin scheduler feeding NCH serial bit streams through one shared
// detector, emitting a registered event (channel index) on each first 1 after a 0.
// Optional build macro MDET_SCHED_CNT_EN adds per-channel saturating event counters
// readable through cnt_sel / cnt_out.
module mdet_sched
  import mdet_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
`ifdef MDET_SCHED_CNT_EN
  input  logic [CW-1:0]    cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
`endif
  mdet_sched_if.slave      bus
);

  det_state_t     st [NCH];
  logic [CW-1:0]  ptr;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_any;
  logic           stall;
  det_state_t     nxt_st;
  logic           step_ev;
  logic           new_ev;
  logic           ev_valid_q;
  logic [CW-1:0]  ev_ch_q;
  int             rr_idx;

  // Grants freeze while an event waits for its consumer, during clear, and in reset.
  assign stall = (ev_valid_q && !bus.ev_ready) || clr || reset;

  // Round-robin pick: first valid channel scanning upward from ptr, with wrap.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    if (!stall) begin
      for (int i = 0; i < NCH; i++) begin
        rr_idx = (int'(ptr) + i) % NCH;
        if (!gnt_any && bus.in_valid[rr_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = CW'(rr_idx);
        end
      end
    end
  end

  assign bus.in_ready = gnt_any ? (NCH'(1) << gnt_idx) : '0;

  det_step u_step (
    .state      (st[gnt_idx]),
    .din        (bus.in_bit[gnt_idx]),
    .next_state (nxt_st),
    .ev         (step_ev)
  );

  assign new_ev = gnt_any && step_ev;

  // Detector states: clear wipes all channels, otherwise only the granted one moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) st[i] <= ST_IDLE;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) st[i] <= ST_IDLE;
    end else if (gnt_any) begin
      st[gnt_idx] <= nxt_st;
    end
  end

  // Round-robin pointer moves just past the last granted channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Event register: new event loads even while the old one is being accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
    end else if (new_ev) begin
      ev_valid_q <= 1'b1;
      ev_ch_q    <= gnt_idx;
    end else if (bus.ev_ready) begin
      ev_valid_q <= 1'b0;
    end
  end

  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_ch    = ev_ch_q;

`ifdef MDET_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt [NCH];

  // Per-channel event counters, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (new_ev && (cnt[gnt_idx] != CNT_MAX)) begin
      cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
    end
  end

  // Counter readback mux; out-of-range selects read zero.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (CW'(i) == cnt_sel) cnt_out = cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_mdet_sched.sv
// Self-checking bench for mdet_sched. The reference model tracks, per channel,
// the last accepted bit (an event is a 1 following a 0 or a clear), a round-robin
// pointer, and the pending event; it is compared against the DUT every cycle.
module tb_mdet_sched;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic reset;
  logic clr;

  always #5 clk = ~clk;

  mdet_sched_if #(.NCH(NCH), .CW(CW)) bus ();

`ifdef MDET_SCHED_CNT_EN
  logic [CW-1:0] cnt_sel;
  logic [7:0]    cnt_out;
`endif

  mdet_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
`ifdef MDET_SCHED_CNT_EN
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out),
`endif
    .bus     (bus)
  );

  // reference model
  int m_ptr;
  bit m_last [NCH];
  bit m_ev_valid;
  int m_ev_ch;
  int m_cnt [NCH];

  int total = 0;
  int bad   = 0;
  int dut_ev_seen = 0;

  logic [NCH-1:0] s_rdy;
  logic           s_ev_valid;
  logic [CW-1:0]  s_ev_ch;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_ev_valid = 1'b0;
    m_ev_ch = 0;
    for (int k = 0; k < NCH; k++) begin
      m_last[k] = 1'b0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic set_in(input logic [NCH-1:0] vld, input logic [NCH-1:0] bits,
                        input logic rdy, input logic c);
    bus.in_valid = vld;
    bus.in_bit   = bits;
    bus.ev_ready = rdy;
    clr          = c;
  endtask

  // One clock: entered at posedge+1 with inputs applied, compares at the negedge,
  // returns at the next posedge+1 with the model advanced.
  task automatic cycle();
    int g;
    logic stall;
    logic clr_s;
    logic rdy_s;
    logic [NCH-1:0] bits_s;
    logic [NCH-1:0] exp_rdy;
    bit ev;
    #4;
    rdy_s  = bus.ev_ready;
    bits_s = bus.in_bit;
    clr_s  = clr;
    stall  = (m_ev_valid && !rdy_s) || clr_s;
    g = -1;
    if (!stall) begin
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (m_ptr + i) % NCH;
        if (g < 0 && bus.in_valid[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    s_rdy      = bus.in_ready;
    s_ev_valid = bus.ev_valid;
    s_ev_ch    = bus.ev_ch;
    check_val("in_ready", 32'(s_rdy), 32'(exp_rdy));
    check_val("ev_valid", 32'(s_ev_valid), 32'(m_ev_valid));
    if (m_ev_valid) check_val("ev_ch", 32'(s_ev_ch), 32'(m_ev_ch));
`ifdef MDET_SCHED_CNT_EN
    check_val("cnt_out", 32'(cnt_out), 32'(m_cnt[cnt_sel]));
`endif
    if (s_ev_valid && rdy_s) dut_ev_seen++;
    @(posedge clk);
    #1;
    ev = 1'b0;
    if (clr_s) begin
      for (int k = 0; k < NCH; k++) begin
        m_last[k] = 1'b0;
        m_cnt[k]  = 0;
      end
    end
    if (g >= 0) begin
      ev = bits_s[g] && !m_last[g];
      m_last[g] = bits_s[g];
      m_ptr = (g + 1) % NCH;
    end
    if (ev) begin
      m_ev_valid = 1'b1;
      m_ev_ch = g;
      if (m_cnt[g] < 255) m_cnt[g]++;
    end else if (rdy_s) begin
      m_ev_valid = 1'b0;
    end
  endtask

  task automatic clr_cycle();
    set_in('0, '0, 1'b1, 1'b1);
    cycle();
  endtask

  initial begin
    int n0;
    logic [5:0] seq030;
    reset = 1'b1;
    clr   = 1'b0;
`ifdef MDET_SCHED_CNT_EN
    cnt_sel = '0;
`endif
    set_in('1, '1, 1'b1, 1'b0);
    model_reset();

    // reset state
    @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check_val("rst_ev_valid", 32'(bus.ev_valid), 32'h0);
    check_val("rst_ev_ch", 32'(bus.ev_ch), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // all channels valid from reset: grants rotate 0,1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      set_in('1, 4'($urandom), 1'b1, 1'b0);
      cycle();
      check_val("rr_order", 32'(s_rdy), 32'(1 << (k % NCH)));
    end

    // channel 0 bits 0,1,1,1,0,1: events on 2nd and 6th accepted bits
    clr_cycle();
    seq030 = 6'b101110;
    n0 = dut_ev_seen;
    for (int k = 0; k < 6; k++) begin
      set_in(4'b0001, {3'b000, seq030[k]}, 1'b1, 1'b0);
      cycle();
    end
    set_in('0, '0, 1'b1, 1'b0);
    cycle();
    check_val("seq_ev_count", 32'(dut_ev_seen - n0), 32'd2);

    // pending event with consumer stalled for 5 cycles
    clr_cycle();
    set_in(4'b0001, 4'b0001, 1'b1, 1'b0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      set_in('1, '1, 1'b0, 1'b0);
      cycle();
      check_val("stall_rdy", 32'(s_rdy), 32'h0);
      check_val("stall_ev_ch", 32'(s_ev_ch), 32'h0);
      check_val("stall_ev_valid", 32'(s_ev_valid), 32'h1);
    end
    set_in('1, '1, 1'b1, 1'b0);
    cycle();
    set_in('0, '0, 1'b1, 1'b0);
    cycle();

    // channel 2 in RUN, clear, then 1 -> fresh event on channel 2
    clr_cycle();
    set_in(4'b0100, 4'b0100, 1'b1, 1'b0);
    cycle();
    cycle();
    clr_cycle();
    set_in(4'b0100, 4'b0100, 1'b1, 1'b0);
    cycle();
    set_in('0, '0, 1'b1, 1'b0);
    cycle();
    check_val("clr_ev_valid", 32'(s_ev_valid), 32'h1);
    check_val("clr_ev_ch", 32'(s_ev_ch), 32'h2);

    // reset mid-stream with an event pending and ptr moved off zero
    clr_cycle();
    set_in(4'b0100, 4'b0100, 1'b0, 1'b0);
    cycle();
    set_in(4'b0110, '1, 1'b0, 1'b0);
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_ev_valid", 32'(bus.ev_valid), 32'h0);
    check_val("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(4'b0110, '1, 1'b1, 1'b0);
    cycle();
    check_val("post_rst_grant", 32'(s_rdy), 32'h2);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      set_in(4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
`ifdef MDET_SCHED_CNT_EN
      cnt_sel = 2'($urandom);
`endif
      cycle();
    end

`ifdef MDET_SCHED_CNT_EN
    // 300 events on channel 1 saturate its counter
    clr_cycle();
    cnt_sel = 2'd1;
    for (int k = 0; k < 600; k++) begin
      set_in(4'b0010, {2'b00, 1'(k % 2), 1'b0}, 1'b1, 1'b0);
      cycle();
    end
    set_in('0, '0, 1'b1, 1'b0);
    cycle();
    for (int c = 0; c < NCH; c++) begin
      cnt_sel = 2'(c);
      #1;
      check_val("cnt_sat", 32'(cnt_out), (c == 1) ? 32'd255 : 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
